mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//   Shares the MUX_4to1 datapath among four requesters. Each cycle, picks one active request
//   round-robin and drives the mux select with its index. Captures the selected operand into an
//   output register with a valid/ready handshake and returns a one-cycle ack to the winner.
//   Instantiates WIDTH copies of MUX_4to1 internally, one per data bit.
// PARAMETERS
//   WIDTH  1  operand width in bits; one MUX_4to1 per bit
// PORTS
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   req_i        in   4      request per source; bit0=src1 .. bit3=src4
//   src1_i       in   WIDTH  operand of requester 0 (src2_i..src4_i likewise for 1..3)
//   src2_i       in   WIDTH  operand of requester 1
//   src3_i       in   WIDTH  operand of requester 2
//   src4_i       in   WIDTH  operand of requester 3
//   ack_o        out  4      one-hot, combinational: grant_o & {4{out_valid_o & out_ready_i}}
//   sel_o        out  2      mux select in use this cycle (winner index while arbitrating)
//   grant_o      out  4      registered one-hot owner of the current output; 0 when idle
//   out_valid_o  out  1      output register holds an unconsumed operand
//   out_ready_i  in   1      consumer accepts out_data_o this cycle
//   out_data_o   out  WIDTH  captured mux result
//   out_id_o     out  2      index of the requester that owns out_data_o
// BEHAVIOUR
//   Reset (async, immediate): out_valid_o=0, out_data_o=0, out_id_o=0, grant_o=0, ptr=0.
//     ack_o is 0 as a consequence. sel_o=0.
//   State: IDLE (out_valid_o=0) and BUSY (out_valid_o=1).
//   Arbitrate when IDLE, or when BUSY and out_ready_i=1 (slot frees this edge).
//   Candidates: req_i & ~mask. mask=grant_o when BUSY, 0 when IDLE.
//     The acked requester is never re-granted on the ack edge.
//   Round-robin: ptr is the highest-priority index; search ptr, ptr+1, .. mod 4.
//     On grant of k: ptr <= (k+1) mod 4, so 3 wraps to 0.
//   sel_o = winner index while a winner exists, else out_id_o.
//     The mux output src[sel_o] is combinational.
//   On an edge with a winner k:
//     out_data_o <= src(k+1)_i; out_id_o <= k; grant_o <= 1<<k; out_valid_o <= 1.
//   On an edge in BUSY with out_ready_i=1 and no winner: out_valid_o <= 0, grant_o <= 0.
//   BUSY, out_ready_i=0: all output registers hold; ptr holds; no new request is sampled.
//   Latency: req high at edge N (IDLE) -> out_valid_o=1 after edge N.
//   Throughput: 1 transfer/cycle with continuous ready and >=2 requesters.
//   Requester contract: hold req_i until its ack_o bit pulses, then deassert next cycle.
//     src may change after the grant edge, because data is captured at grant.
//   Reset mid-transfer: the pending operand is discarded; no ack is issued.
//   req_i=0 throughout: stays IDLE; ptr unchanged.
// CONFIGURATION
//   MUX_ARB_FIXED_PRIO_EN defined: fixed priority, src1 > src2 > src3 > src4.
//     ptr is held at 0; the ack-edge mask rule still applies.
//   Not defined (default): round-robin as above.
// TESTING
//   1. Reset with req_i=4'b1111 -> all outputs 0; after release, edge1: out_id_o=0, grant_o=4'b0001.
//   2. req_i=4'b1111, out_ready_i=1, srcs=1,0,1,0 (WIDTH=1) -> out_id_o sequence 0,1,2,3,0,
//      out_data_o 1,0,1,0,1; each ack_o one-hot, one per cycle.
//   3. Single req_i=4'b0100, src3_i=1, out_ready_i=0 for 3 cycles -> out_valid_o=1, out_data_o=1
//      held, ack_o=0; ready=1 -> ack_o=4'b0100, then IDLE.
//   4. Wrap: grant 3 (ptr->0), then req_i=4'b1001 -> next grant is 0, not 3.
//   5. rst_n low mid-BUSY with out_ready_i=0 -> out_valid_o drops immediately, no ack; ptr=0.
//   6. With MUX_ARB_FIXED_PRIO_EN, req_i=4'b1111 held, ready=1 -> grants alternate 0,1,0,1
//      (mask only excludes the acked index).

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares a bit-sliced 4:1 mux among four requesters and registers the winner's operand.
// Optional macro MUX_ARB_FIXED_PRIO_EN switches to fixed priority (src1 highest).

module MUX_4to1 (
  input  logic       in0_i,
  input  logic       in1_i,
  input  logic       in2_i,
  input  logic       in3_i,
  input  logic [1:0] sel_i,
  output logic       y_o
);
  always_comb begin
    y_o = in0_i;
    case (sel_i)
      2'd0: y_o = in0_i;
      2'd1: y_o = in1_i;
      2'd2: y_o = in2_i;
      2'd3: y_o = in3_i;
      default: y_o = in0_i;
    endcase
  end
endmodule

module mux_rr_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [WIDTH-1:0] src3_i,
  input  logic [WIDTH-1:0] src4_i,
  output logic [3:0]       ack_o,
  output logic [1:0]       sel_o,
  output logic [3:0]       grant_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       out_id_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       id_q;
  logic [1:0]       ptr_q;
  logic [1:0]       ptr_d;
  logic [3:0]       grant_q;

  logic             arb_en;
  logic [3:0]       mask;
  logic [3:0]       cand;
  logic             win_valid;
  logic [1:0]       win_idx;
  logic [1:0]       idx;
  logic [WIDTH-1:0] mux_y;

  // The slot can be refilled on the same edge the consumer drains it.
  assign arb_en = (state_q == IDLE) || out_ready_i;
  assign mask   = (state_q == BUSY) ? grant_q : 4'b0000;
  assign cand   = req_i & ~mask;

  // Scan from farthest to nearest so the index closest to ptr_q wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    idx       = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (cand[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
    end
    win_valid = win_valid & arb_en;
  end

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign ptr_d = 2'd0;
`else
  assign ptr_d = win_idx + 2'd1;
`endif

  assign sel_o = win_valid ? win_idx : id_q;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      MUX_4to1 u_mux (
        .in0_i (src1_i[gi]),
        .in1_i (src2_i[gi]),
        .in2_i (src3_i[gi]),
        .in3_i (src4_i[gi]),
        .sel_i (sel_o),
        .y_o   (mux_y[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      id_q    <= 2'd0;
      ptr_q   <= 2'd0;
      grant_q <= 4'b0000;
    end else if (win_valid) begin
      state_q <= BUSY;
      data_q  <= mux_y;
      id_q    <= win_idx;
      ptr_q   <= ptr_d;
      grant_q <= 4'b0001 << win_idx;
    end else if (state_q == BUSY && out_ready_i) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
    end
  end

  assign out_valid_o = (state_q == BUSY);
  assign out_data_o  = data_q;
  assign out_id_o    = id_q;
  assign grant_o     = grant_q;
  assign ack_o       = grant_q & {4{out_valid_o & out_ready_i}};

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter (default round-robin build, WIDTH=4).

module tb_mux_rr_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_i;
  logic [W-1:0] src [4];
  logic [3:0]   ack_o;
  logic [1:0]   sel_o;
  logic [3:0]   grant_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] out_data_o;
  logic [1:0]   out_id_o;

  int total = 0;
  int bad   = 0;

  // Reference state: slot occupancy, owner, last id, priority pointer.
  logic       m_valid;
  logic [1:0] m_own;
  logic [1:0] m_id;
  logic [1:0] m_ptr;
  logic [3:0] last_ack;
  logic [5:0] sb_q [$];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .src1_i      (src[0]),
    .src2_i      (src[1]),
    .src3_i      (src[2]),
    .src4_i      (src[3]),
    .ack_o       (ack_o),
    .sel_o       (sel_o),
    .grant_o     (grant_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_id_o    (out_id_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] c, input logic [1:0] p);
    for (int d = 0; d < 4; d++) begin
      if (c[(int'(p) + d) % 4]) return (int'(p) + d) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_own   = 2'd0;
    m_id    = 2'd0;
    m_ptr   = 2'd0;
  endtask

  // Called at posedge+1: drive, check, predict, advance one edge.
  task automatic cyc(input logic [3:0] req, input logic rdy);
    logic [3:0] own_mask;
    logic [3:0] cand;
    logic [5:0] e;
    int w;
    req_i       = req;
    out_ready_i = rdy;
    for (int s = 0; s < 4; s++) src[s] = W'($urandom);
    #1;
    own_mask = m_valid ? (4'b0001 << m_own) : 4'b0000;
    last_ack = (m_valid && rdy) ? own_mask : 4'b0000;
    check_val("ack", 32'(ack_o), 32'(last_ack));
    check_val("valid", 32'(out_valid_o), 32'(m_valid));
    check_val("grant", 32'(grant_o), 32'(own_mask));
    if (m_valid && rdy) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_val("out_id", 32'(out_id_o), 32'(e[5:4]));
        check_val("out_data", 32'(out_data_o), 32'(e[3:0]));
        $display("xfer id=%0d data=%0h ack=%b", out_id_o, out_data_o, ack_o);
      end
    end
    cand = req & ~own_mask;
    w = (!m_valid || rdy) ? pick(cand, m_ptr) : -1;
    check_val("sel", 32'(sel_o), (w >= 0) ? 32'(w) : 32'(m_id));
    if (w >= 0) sb_q.push_back({2'(w), src[w]});
    @(posedge clk);
    if (w >= 0) begin
      m_valid = 1'b1;
      m_own   = 2'(w);
      m_id    = 2'(w);
      m_ptr   = 2'(w + 1);
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [3:0] pend;
    logic [3:0] nreq;
    rst_n       = 1'b0;
    req_i       = 4'b1111;
    out_ready_i = 1'b0;
    for (int s = 0; s < 4; s++) src[s] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", 32'(out_valid_o), 32'd0);
    check_val("rst_data", 32'(out_data_o), 32'd0);
    check_val("rst_id", 32'(out_id_o), 32'd0);
    check_val("rst_grant", 32'(grant_o), 32'd0);
    check_val("rst_ack", 32'(ack_o), 32'd0);
    check_val("rst_sel", 32'(sel_o), 32'd0);
    rst_n = 1'b1;

    // First grant after reset goes to index 0, then full rotation.
    cyc(4'b1111, 1'b0);
    check_val("first_grant", 32'(grant_o), 32'b0001);
    for (int i = 0; i < 6; i++) cyc(4'b1111, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);

    // Single requester held off by backpressure.
    cyc(4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b1);
    cyc(4'b0000, 1'b0);
    check_val("idle_after_ack", 32'(out_valid_o), 32'd0);

    // Pointer wrap: grant 3, then 0 must beat 3.
    cyc(4'b1000, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b1001, 1'b1);
    check_val("wrap_grant", 32'(grant_o), 32'b0001);
    cyc(4'b0000, 1'b1);

    // Reset while busy with backpressure.
    cyc(4'b0010, 1'b0);
    cyc(4'b0010, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_valid", 32'(out_valid_o), 32'd0);
    check_val("midrst_ack", 32'(ack_o), 32'd0);
    check_val("midrst_grant", 32'(grant_o), 32'd0);
    sb_q.delete();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(4'b1001, 1'b1);
    check_val("ptr_after_rst", 32'(grant_o), 32'b0001);
    cyc(4'b0000, 1'b1);

    // No requests: stays idle.
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b1);

    // Random contract-following traffic.
    pend = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      nreq = pend | 4'($urandom);
      cyc(nreq, 1'($urandom_range(0, 3) != 0));
      pend = nreq & ~last_ack;
    end
    for (int i = 0; i < 6; i++) begin
      cyc(pend, 1'b1);
      pend = pend & ~last_ack;
    end
    cyc(4'b0000, 1'b1);
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
